vga_pattern_gen: RTL
====================

Name: vga_pattern_gen

Overview:
- Pixel source stage directly downstream of the horizontal and vertical timing controllers.
- Consumes x_idx, y_idx, vertical video_enable and the active-low h_sync and v_sync.
- Produces registered RGB, plus sync and data-enable outputs that stay aligned with the RGB.
- Generates four selectable test patterns; pattern changes and animation update only at frame boundaries.

Parameters:
- H_ACTIVE, 1920: active pixels per line.
- V_ACTIVE, 1080: active lines per frame.
- COLOR_W, 4: bits per colour channel; legal range 1-8.
- BOX_SIZE, 64: side length of the moving box in pattern 3; must be less than both H_ACTIVE and V_ACTIVE.

Ports:
- clk, input, 1: pixel clock.
- reset, input, 1: asynchronous, active-high reset.
- x_idx, input, 12: horizontal pixel index from the horizontal timing controller.
- y_idx, input, 12: line index from the vertical timing controller.
- video_enable, input, 1: vertical active-region flag.
- h_sync_in, input, 1: active-low horizontal sync.
- v_sync_in, input, 1: active-low vertical sync.
- pattern_sel, input, 2: requested pattern, 0 to 3.
- red, output, COLOR_W: red channel.
- green, output, COLOR_W: green channel.
- blue, output, COLOR_W: blue channel.
- h_sync_out, output, 1: h_sync_in delayed by 2 cycles.
- v_sync_out, output, 1: v_sync_in delayed by 2 cycles.
- de_out, output, 1: pixel-active flag aligned with RGB.
- frame_count, output, 16: number of frames completed.

Behaviour:
- Reset (asynchronous, active-high):
  - red, green, blue = 0; de_out = 0; h_sync_out = 1; v_sync_out = 1; frame_count = 0.
  - Active pattern = 0; box_x = 0, box_y = 0; both box directions = +1; v_sync history register = 1.
- Reset asserted mid-frame: all pipeline stages clear immediately. After release, outputs stay at reset values until real data reaches stage 2.
- Pipeline, fixed latency 2 cycles from any input to the corresponding outputs:
  - Stage 1 registers x_idx, y_idx, both syncs and de1 = video_enable AND (x_idx < H_ACTIVE). It also registers bar index, checker bit and box hit.
  - Stage 2 registers the RGB and delayed syncs.
  - h_sync_out, v_sync_out and de_out follow their inputs with exactly 2 cycles of delay.
- RGB is forced to 0 whenever stage-2 de is 0.
- Frame boundary is the cycle on which v_sync_in is 0 and its registered previous value is 1 (falling edge). On that cycle:
  - frame_count increments, wrapping 0xFFFF to 0.
  - Active pattern latches pattern_sel. pattern_sel is ignored on every other cycle.
  - The box moves one step per axis, as below.
- Box step, x axis (y axis is identical, using V_ACTIVE):
  - Direction + and box_x == H_ACTIVE - BOX_SIZE: direction becomes -, box_x decrements.
  - Direction - and box_x == 0: direction becomes +, box_x becomes 1.
  - Otherwise box_x moves by 1 in the current direction.
  - The box never leaves the active area.
- Pattern 0, colour bars:
  - 8 vertical bars, each H_ACTIVE/8 pixels wide (integer division). Bar index comes from a comparator chain; no divider.
  - Bar order from the left: white, yellow, cyan, green, magenta, red, blue, black.
  - "Full" means all ones on a channel; unused channels are 0.
  - Any remainder pixels at the right edge use bar 7.
- Pattern 1, checkerboard: x_idx[6] XOR y_idx[6]. 1 gives white (all channels full); 0 gives black.
- Pattern 2, gradient:
  - red = x_idx[10:11-COLOR_W].
  - green = y_idx[10:11-COLOR_W].
  - blue = frame_count[COLOR_W-1:0].
- Pattern 3, moving box:
  - Pixels with box_x <= x < box_x + BOX_SIZE and box_y <= y < box_y + BOX_SIZE are white.
  - All other pixels are blue = MSB only, red = green = 0.
- Box coordinates used for rendering come from the frame-boundary registers, so the box never tears within a frame.
- Simultaneous frame boundary and a pattern_sel change: the new value is used for the entire next frame.
- Out-of-range indices (x_idx >= H_ACTIVE, or video_enable = 0) never produce colour.

Optional Feature:
- Macro: PATTERN_GEN_BORDER_EN.
- Defined: pixels with x == 0, x == H_ACTIVE-1, y == 0 or y == V_ACTIVE-1 are forced to white in every pattern. This overrides pattern colour only; timing and latency are unchanged.
- Undefined: no border logic is present, and output is the pure pattern.

Test Plan:
- Reset release, then a full frame with defaults: h_sync_out and v_sync_out equal the inputs delayed by exactly 2 clk; de_out is high for exactly 1920x1080 cycles.
- pattern_sel=0, line y=10: x=0 gives RGB=F,F,F; x=240 gives F,F,0; x=1679 gives 0,0,F; x=1680 gives 0,0,0; x=1920 gives 0,0,0.
- pattern_sel switched from 1 to 2 mid-frame: the remainder of the current frame stays checkerboard; gradient starts at the next v_sync falling edge; frame_count increments by 1 there.
- Pattern 3, run 1857 frames: box_x reaches 1856, then reads 1855 on the following frame. box_y bounces at 1016 and returns to 0, then reads 1. Pixel (box_x, box_y) is white; pixel (box_x+64, box_y) is 0,0,8.
- Preload frame_count to 0xFFFF via 65535 fast frames or force: the next boundary wraps it to 0. Assert reset mid-line: all outputs return to reset values in the same cycle.
- PATTERN_GEN_BORDER_EN defined, pattern 2: pixels (0,500), (1919,500), (700,0) and (700,1079) are F,F,F; pixel (1,1) shows the gradient value.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: two-stage pixel pipeline rendering colour bars, checkerboard, gradient
// and a bouncing box. Optional white frame border when PATTERN_GEN_BORDER_EN is defined.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int COLOR_W  = 4,
  parameter int BOX_SIZE = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        x_idx,
  input  logic [11:0]        y_idx,
  input  logic               video_enable,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic [1:0]         pattern_sel,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic               de_out,
  output logic [15:0]        frame_count
);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [COLOR_W-1:0] FULL     = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] ZERO     = {COLOR_W{1'b0}};
  localparam logic [COLOR_W-1:0] BLUE_MSB = FULL ^ (FULL >> 1);

  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  endfunction

  // One bounce step on an axis; returns {dir, pos}, dir 1 meaning increasing.
  function automatic logic [12:0] axis_step(input logic dir, input logic [11:0] pos,
                                            input logic [11:0] lim);
    if (dir) begin
      if (pos == lim) axis_step = {1'b0, pos - 12'd1};
      else            axis_step = {1'b1, pos + 12'd1};
    end else begin
      if (pos == 12'd0) axis_step = {1'b1, 12'd1};
      else              axis_step = {1'b0, pos - 12'd1};
    end
  endfunction

  logic               frame_edge;
  logic [15:0]        frame_count_d, frame_count_q;
  logic [1:0]         pattern_d, pattern_q;
  logic [11:0]        box_x_d, box_x_q, box_y_d, box_y_q;
  logic               dir_x_d, dir_x_q, dir_y_d, dir_y_q;
  logic               de1_d, de1_q, hs1_d, hs1_q, vs1_d, vs1_q;
  logic [2:0]         bar1_d, bar1_q;
  logic               chk1_d, chk1_q, hit1_d, hit1_q;
  logic [COLOR_W-1:0] grad_r1_d, grad_r1_q, grad_g1_d, grad_g1_q;
  logic [COLOR_W-1:0] red_d, red_q, green_d, green_q, blue_d, blue_q;
  logic               de2_d, de2_q, hs2_d, hs2_q, vs2_d, vs2_q;
  logic [2:0]         bar_c;
`ifdef PATTERN_GEN_BORDER_EN
  logic               border1_d, border1_q;
`endif

  // vs1_q doubles as the v_sync history used for falling-edge detection.
  always_comb begin
    frame_edge          = ~v_sync_in & vs1_q;
    frame_count_d       = frame_count_q;
    pattern_d           = pattern_q;
    {dir_x_d, box_x_d}  = {dir_x_q, box_x_q};
    {dir_y_d, box_y_d}  = {dir_y_q, box_y_q};
    if (frame_edge) begin
      frame_count_d      = frame_count_q + 16'd1;
      pattern_d          = pattern_sel;
      {dir_x_d, box_x_d} = axis_step(dir_x_q, box_x_q, 12'(H_ACTIVE - BOX_SIZE));
      {dir_y_d, box_y_d} = axis_step(dir_y_q, box_y_q, 12'(V_ACTIVE - BOX_SIZE));
    end
  end

  always_comb begin
    de1_d  = video_enable & (x_idx < 12'(H_ACTIVE));
    hs1_d  = h_sync_in;
    vs1_d  = v_sync_in;
    bar1_d = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (x_idx < 12'((i + 1) * BAR_W)) bar1_d = 3'(i);
    end
    chk1_d = x_idx[6] ^ y_idx[6];
    hit1_d = (x_idx >= box_x_q) && ({1'b0, x_idx} < ({1'b0, box_x_q} + 13'(BOX_SIZE))) &&
             (y_idx >= box_y_q) && ({1'b0, y_idx} < ({1'b0, box_y_q} + 13'(BOX_SIZE)));
    grad_r1_d = x_idx[10 -: COLOR_W];
    grad_g1_d = y_idx[10 -: COLOR_W];
`ifdef PATTERN_GEN_BORDER_EN
    border1_d = (x_idx == 12'd0) || (x_idx == 12'(H_ACTIVE - 1)) ||
                (y_idx == 12'd0) || (y_idx == 12'(V_ACTIVE - 1));
`endif
  end

  always_comb begin
    bar_c   = bar_rgb(bar1_q);
    red_d   = ZERO;
    green_d = ZERO;
    blue_d  = ZERO;
    case (pattern_q)
      2'd0: begin
        red_d   = {COLOR_W{bar_c[2]}};
        green_d = {COLOR_W{bar_c[1]}};
        blue_d  = {COLOR_W{bar_c[0]}};
      end
      2'd1: begin
        red_d   = chk1_q ? FULL : ZERO;
        green_d = chk1_q ? FULL : ZERO;
        blue_d  = chk1_q ? FULL : ZERO;
      end
      2'd2: begin
        red_d   = grad_r1_q;
        green_d = grad_g1_q;
        blue_d  = frame_count_q[COLOR_W-1:0];
      end
      2'd3: begin
        red_d   = hit1_q ? FULL : ZERO;
        green_d = hit1_q ? FULL : ZERO;
        blue_d  = hit1_q ? FULL : BLUE_MSB;
      end
      default: begin
        red_d   = ZERO;
        green_d = ZERO;
        blue_d  = ZERO;
      end
    endcase
`ifdef PATTERN_GEN_BORDER_EN
    if (border1_q) begin
      red_d   = FULL;
      green_d = FULL;
      blue_d  = FULL;
    end
`endif
    if (!de1_q) begin
      red_d   = ZERO;
      green_d = ZERO;
      blue_d  = ZERO;
    end
    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= 16'd0;
      pattern_q     <= 2'd0;
      box_x_q       <= 12'd0;
      box_y_q       <= 12'd0;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      de1_q         <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      bar1_q        <= 3'd0;
      chk1_q        <= 1'b0;
      hit1_q        <= 1'b0;
      grad_r1_q     <= ZERO;
      grad_g1_q     <= ZERO;
      red_q         <= ZERO;
      green_q       <= ZERO;
      blue_q        <= ZERO;
      de2_q         <= 1'b0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
`ifdef PATTERN_GEN_BORDER_EN
      border1_q     <= 1'b0;
`endif
    end else begin
      frame_count_q <= frame_count_d;
      pattern_q     <= pattern_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      de1_q         <= de1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      bar1_q        <= bar1_d;
      chk1_q        <= chk1_d;
      hit1_q        <= hit1_d;
      grad_r1_q     <= grad_r1_d;
      grad_g1_q     <= grad_g1_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      de2_q         <= de2_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
`ifdef PATTERN_GEN_BORDER_EN
      border1_q     <= border1_d;
`endif
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign de_out      = de2_q;
  assign h_sync_out  = hs2_q;
  assign v_sync_out  = vs2_q;
  assign frame_count = frame_count_q;

endmodule
